// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan decoder.
// Glyph bit order is a..g on [6:0].
package seg7_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] GLYPH_0 = 7'h7E;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'h30;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'h33;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'h5F;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'h70;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'h7B;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'h1F;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'h4E;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'h3D;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'h47;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_PRESENT = 1'b1
  } frame_state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational glyph-to-hex decoder; unknown patterns decode to 0 with err set.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] glyph,
  output logic [3:0]       hex,
  output logic             err
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    hex = 4'h0;
    err = 1'b0;
    case (glyph)
      GLYPH_0: hex = 4'h0;
      GLYPH_1: hex = 4'h1;
      GLYPH_2: hex = 4'h2;
      GLYPH_3: hex = 4'h3;
      GLYPH_4: hex = 4'h4;
      GLYPH_5: hex = 4'h5;
      GLYPH_6: hex = 4'h6;
      GLYPH_7: hex = 4'h7;
      GLYPH_8: hex = 4'h8;
      GLYPH_9: hex = 4'h9;
      GLYPH_A: hex = 4'hA;
      GLYPH_B: hex = 4'hB;
      GLYPH_C: hex = 4'hC;
      GLYPH_D: hex = 4'hD;
      GLYPH_E: hex = 4'hE;
      GLYPH_F: hex = 4'hF;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed 7-segment bus, captures each settled digit and
// hands out complete frames on a valid/ready port.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NDIG-1:0]      an,
  input  logic [SEG_W-1:0]     a_to_g,
  output logic [4*NDIG-1:0]    frame_data,
  output logic [NDIG-1:0]      frame_err,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic                 overflow
);

  localparam int CNT_W = $clog2(STABLE_CYC);
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);

  logic [NDIG-1:0]          an_q, an_q2;
  logic [SEG_W-1:0]         seg_q, seg_q2;
  logic [CNT_W-1:0]         stable_cnt;
  logic                     captured;
  logic [NDIG-1:0]          mask;
  logic [NDIG-1:0][3:0]     slot_hex;
  logic [NDIG-1:0]          slot_err;
  frame_state_e             state;

  logic                     same;
  logic                     one_hot;
  logic                     capture;
  logic                     mask_full;
  logic [IDX_W-1:0]         idx;
  logic [3:0]               dec_hex;
  logic                     dec_err;

  assign same      = ({an_q, seg_q} == {an_q2, seg_q2});
  assign one_hot   = $onehot(an_q2);
  // The counter was built on the an_q2/seg_q2 history, so that is the settled value to capture.
  assign capture   = (stable_cnt == CNT_MAX) && !captured && one_hot;
  assign mask_full = &mask;

  always_comb begin
    idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (an_q2[i]) idx = IDX_W'(i);
    end
  end

  seg7_to_hex u_dec (
    .glyph (seg_q2),
    .hex   (dec_hex),
    .err   (dec_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q       <= '0;
      an_q2      <= '0;
      seg_q      <= '0;
      seg_q2     <= '0;
      stable_cnt <= '0;
      captured   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register here sees the pre-edge values of the others.
      an_q   <= an;
      seg_q  <= a_to_g;
      an_q2  <= an_q;
      seg_q2 <= seg_q;
      if (!same) begin
        stable_cnt <= '0;
        captured   <= 1'b0;
      end else begin
        if (stable_cnt != CNT_MAX) stable_cnt <= stable_cnt + CNT_W'(1);
        if (capture) captured <= 1'b1;
      end
    end
  end

  // NOTE: the slot array is reset so a mid-frame reset leaves no stale digits behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_hex <= '0;
      slot_err <= '0;
    end else if (capture) begin
      slot_hex[idx] <= dec_hex;
      slot_err[idx] <= dec_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_COLLECT;
      mask        <= '0;
      frame_data  <= '0;
      frame_err   <= '0;
      frame_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      overflow <= 1'b0;
      // A capture landing on the clearing edge belongs to the next frame.
      mask <= (mask_full ? '0 : mask) | (capture ? an_q2 : '0);
      case (state)
        ST_COLLECT: begin
          if (mask_full) begin
            frame_data  <= slot_hex;
            frame_err   <= slot_err;
            frame_valid <= 1'b1;
            state       <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (mask_full) begin
            if (frame_ready) begin
              frame_data <= slot_hex;
              frame_err  <= slot_err;
            end else begin
              overflow <= 1'b1;
            end
          end else if (frame_ready) begin
            frame_valid <= 1'b0;
            state       <= ST_COLLECT;
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: frame vectors plus multi-cycle corner sequences.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  a_to_g;
  logic [15:0] frame_data;
  logic [3:0]  frame_err;
  logic        frame_valid;
  logic        frame_ready;
  logic        overflow;

  seg7_scan_decoder #(.NDIG(4), .STABLE_CYC(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an          (an),
    .a_to_g      (a_to_g),
    .frame_data  (frame_data),
    .frame_err   (frame_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][6:0] seg;
    logic [15:0]     data;
    logic [3:0]      err;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int nframes  = 0;
  int ovf_cnt  = 0;
  int rise_cyc = -1;
  int last_t0  = 0;
  logic [15:0] acc_data = '0;
  logic [3:0]  acc_err  = '0;
  logic        valid_d  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake observer: inputs change 2 time units after posedge, so negedge sees the
  // values the next posedge will act on.
  always @(negedge clk) begin
    if (frame_valid && frame_ready) begin
      nframes  = nframes + 1;
      acc_data = frame_data;
      acc_err  = frame_err;
    end
    if (overflow) ovf_cnt = ovf_cnt + 1;
    if (frame_valid && !valid_d) rise_cyc = cyc;
    valid_d = frame_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an      = a;
    a_to_g  = s;
    last_t0 = cyc + 1;
    repeat (n) step();
  endtask

  task automatic scan(input logic [3:0][6:0] segs, input int hold);
    for (int d = 0; d < 4; d++) drive(4'b0001 << d, segs[d], hold);
  endtask

  vec_t vecs [5];
  int   n0, o0;
  logic [3:0][6:0] fa, fb;

  initial begin
    vecs[0] = '{seg: {7'h79, 7'h6D, 7'h30, 7'h7E}, data: 16'h3210, err: 4'b0000};
    vecs[1] = '{seg: {7'h79, 7'h00, 7'h30, 7'h77}, data: 16'h301A, err: 4'b0100};
    vecs[2] = '{seg: {7'h3D, 7'h1F, 7'h47, 7'h4F}, data: 16'hDBFE, err: 4'b0000};
    vecs[3] = '{seg: {7'h7F, 7'h70, 7'h5F, 7'h5B}, data: 16'h8765, err: 4'b0000};
    vecs[4] = '{seg: {7'h08, 7'h4E, 7'h7B, 7'h33}, data: 16'h0C94, err: 4'b1000};
    fa = vecs[0].seg;
    fb = vecs[3].seg;

    rst_n = 1'b0; an = '0; a_to_g = '0; frame_ready = 1'b0;
    repeat (3) step();
    check("rst_valid", 32'(frame_valid), 32'h0);
    check("rst_data", 32'(frame_data), 32'h0);
    check("rst_err", 32'(frame_err), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    rst_n = 1'b1;
    step();

    // Frame vectors with ready high: each frame is handed out 1 cycle after the 4th capture.
    frame_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      n0 = nframes;
      scan(vecs[v].seg, 20);
      check($sformatf("vec%0d_count", v), 32'(nframes), 32'(n0 + 1));
      check($sformatf("vec%0d_data", v), 32'(acc_data), 32'(vecs[v].data));
      check($sformatf("vec%0d_err", v), 32'(acc_err), 32'(vecs[v].err));
      check($sformatf("vec%0d_latency", v), 32'(rise_cyc), 32'(last_t0 + 18));
      check($sformatf("vec%0d_valid_drop", v), 32'(frame_valid), 32'h0);
    end

    // Short holds are ignored; 15 samples is not enough, 16 is.
    n0 = nframes;
    drive(4'b0001, 7'h7E, 20);
    drive(4'b0010, 7'h30, 20);
    drive(4'b0100, 7'h6D, 10);
    drive(4'b1000, 7'h79, 20);
    drive(4'b0000, 7'h00, 5);
    check("short_hold_no_frame", 32'(nframes), 32'(n0));
    check("short_hold_valid", 32'(frame_valid), 32'h0);
    drive(4'b0100, 7'h6D, 15);
    drive(4'b0000, 7'h00, 4);
    check("hold15_no_frame", 32'(nframes), 32'(n0));
    drive(4'b0100, 7'h6D, 16);
    drive(4'b0000, 7'h00, 5);
    check("hold16_frame", 32'(nframes), 32'(n0 + 1));
    check("hold16_data", 32'(acc_data), 32'h3210);

    // Multi-hot and blank selects never capture.
    n0 = nframes;
    drive(4'b0001, 7'h7E, 20);
    drive(4'b0010, 7'h30, 20);
    drive(4'b0110, 7'h6D, 40);
    drive(4'b0000, 7'h79, 40);
    drive(4'b1000, 7'h79, 20);
    drive(4'b0000, 7'h00, 5);
    check("multihot_no_frame", 32'(nframes), 32'(n0));
    drive(4'b0100, 7'h6D, 20);
    drive(4'b0000, 7'h00, 5);
    check("multihot_then_frame", 32'(nframes), 32'(n0 + 1));
    check("multihot_data", 32'(acc_data), 32'h3210);

    // Back-pressure: second frame dropped with a single overflow pulse.
    frame_ready = 1'b0;
    n0 = nframes;
    o0 = ovf_cnt;
    scan(fa, 20);
    check("bp_first_valid", 32'(frame_valid), 32'h1);
    scan(fb, 20);
    drive(4'b0000, 7'h00, 5);
    check("bp_ovf_once", 32'(ovf_cnt), 32'(o0 + 1));
    check("bp_hold_valid", 32'(frame_valid), 32'h1);
    check("bp_hold_data", 32'(frame_data), 32'h3210);
    check("bp_no_accept", 32'(nframes), 32'(n0));
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    check("bp_accept", 32'(nframes), 32'(n0 + 1));
    check("bp_accept_data", 32'(acc_data), 32'h3210);
    check("bp_valid_drop", 32'(frame_valid), 32'h0);

    // Accept and completion on the same edge: new frame loaded, no overflow.
    n0 = nframes;
    o0 = ovf_cnt;
    scan(fa, 20);
    for (int d = 0; d < 3; d++) drive(4'b0001 << d, fb[d], 20);
    an = 4'b1000;
    a_to_g = fb[3];
    repeat (18) step();
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    check("same_valid", 32'(frame_valid), 32'h1);
    check("same_data", 32'(frame_data), 32'h8765);
    check("same_ovf", 32'(overflow), 32'h0);
    check("same_old_accept", 32'(acc_data), 32'h3210);
    drive(4'b0000, 7'h00, 5);
    check("same_ovf_count", 32'(ovf_cnt), 32'(o0));
    frame_ready = 1'b1;
    step();
    check("same_new_accept", 32'(acc_data), 32'h8765);
    check("same_count", 32'(nframes), 32'(n0 + 2));
    check("same_valid_drop", 32'(frame_valid), 32'h0);

    // Asynchronous reset mid-frame discards pending and partial frames.
    frame_ready = 1'b0;
    scan(fa, 20);
    drive(4'b0001, 7'h5B, 20);
    drive(4'b0010, 7'h5F, 20);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(frame_valid), 32'h0);
    check("async_rst_data", 32'(frame_data), 32'h0);
    check("async_rst_err", 32'(frame_err), 32'h0);
    check("async_rst_ovf", 32'(overflow), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    frame_ready = 1'b1;
    n0 = nframes;
    drive(4'b0100, 7'h70, 20);
    drive(4'b1000, 7'h7F, 20);
    drive(4'b0000, 7'h00, 5);
    check("post_rst_partial", 32'(nframes), 32'(n0));
    check("post_rst_valid", 32'(frame_valid), 32'h0);
    drive(4'b0001, 7'h33, 20);
    drive(4'b0010, 7'h7B, 20);
    drive(4'b0000, 7'h00, 5);
    check("post_rst_frame", 32'(nframes), 32'(n0 + 1));
    check("post_rst_data", 32'(acc_data), 32'h8794);
    check("post_rst_err", 32'(acc_err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
